// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared FSM state, default screen size and sprite index constants
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } blit_state_t;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;

    localparam int ROCK    = 0;
    localparam int SCISSOR = 1;
    localparam int PAPER   = 2;

endpackage

// File: rtl/blit_scan_counter.sv
// rtl/blit_scan_counter.sv - row-major sx/sy raster counter over the sprite with last-pixel flag
module blit_scan_counter #(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int SXW   = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    parameter int SYW   = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           enable,
    output logic [SXW-1:0] sx,
    output logic [SYW-1:0] sy,
    output logic           last
);

    logic sx_end;
    logic sy_end;

    assign sx_end = (sx == SXW'(SPR_W - 1));
    assign sy_end = (sy == SYW'(SPR_H - 1));
    assign last   = sx_end && sy_end;

    // Wrapping sy on the last pixel leaves the counter at address 0 for the next blit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            sx <= '0;
            sy <= '0;
        end else if (enable) begin
            if (sx_end) begin
                sx <= '0;
                sy <= sy_end ? '0 : sy + SYW'(1);
            end else begin
                sx <= sx + SXW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite blitter top: FSM, two-stage pixel pipeline and clipping.
// Define SPRITE_BLITTER_TRANSPARENT_EN to make ROM bit-0 pixels transparent.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SCREEN_W    = DEFAULT_SCREEN_W,
    parameter int SCREEN_H    = DEFAULT_SCREEN_H,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int NUM_SPRITES = 3,
    parameter int COLOUR_BITS = 3,
    parameter int XW   = $clog2(SCREEN_W),
    parameter int YW   = $clog2(SCREEN_H),
    parameter int SELW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    parameter int AW   = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SELW-1:0]        sprite_sel,
    input  logic [XW-1:0]          x0,
    input  logic [YW-1:0]          y0,
    input  logic [COLOUR_BITS-1:0] fg_colour,
    input  logic [COLOUR_BITS-1:0] bg_colour,
    output logic [AW-1:0]          rom_addr,
    output logic [SELW-1:0]        rom_sel,
    input  logic                   rom_q,
    output logic [XW-1:0]          x,
    output logic [YW-1:0]          y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int SXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int SYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [SELW:0] NUM_SEL = (SELW + 1)'(NUM_SPRITES);

    blit_state_t state_q, state_d;
    logic drain_q, drain_d;
    logic accept, scan_en, last;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;

    logic [XW-1:0]          x0_q;
    logic [YW-1:0]          y0_q;
    logic [COLOUR_BITS-1:0] fg_q, bg_q;

    logic          s1_valid;
    logic [XW:0]   s1_x;
    logic [YW:0]   s1_y;
    logic          on_screen, pix_on;

    blit_scan_counter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SXW(SXW), .SYW(SYW)
    ) u_scan (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .enable(scan_en),
        .sx    (sx),
        .sy    (sy),
        .last  (last)
    );

    // A start in the DONE cycle is taken so blits can run back to back.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        accept  = 1'b0;
        scan_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                drain_d = 1'b0;
                if (last) state_d = DRAIN;
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == SCAN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign rom_addr = AW'(sy) * AW'(SPR_W) + AW'(sx);

    assign on_screen = (s1_x < (XW + 1)'(SCREEN_W)) && (s1_y < (YW + 1)'(SCREEN_H));
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
    assign pix_on = rom_q;
`else
    assign pix_on = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            drain_q  <= 1'b0;
            rom_sel  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (accept) begin
                rom_sel <= ({1'b0, sprite_sel} >= NUM_SEL) ? '0 : sprite_sel;
                x0_q    <= x0;
                y0_q    <= y0;
                fg_q    <= fg_colour;
                bg_q    <= bg_colour;
            end
            // Stage 1 lines up with rom_q, stage 2 is the registered pixel write.
            s1_valid <= scan_en;
            s1_x     <= {1'b0, x0_q} + (XW + 1)'(sx);
            s1_y     <= {1'b0, y0_q} + (YW + 1)'(sy);
            plot     <= s1_valid && on_screen && pix_on;
            x        <= s1_x[XW-1:0];
            y        <= s1_y[YW-1:0];
            colour   <= rom_q ? fg_q : bg_q;
        end
    end

endmodule
